// File: rtl/rng_pkg.sv
// Shared types for the RNG word packer: collector FSM states and health-test limit.
// The repetition-count health test is enabled by defining RNG_PACK_RCT_EN.
package rng_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } pack_state_e;

  // A run of this many identical accepted bits fails the repetition-count test.
  function automatic int unsigned rct_limit(input int unsigned word_w);
    return word_w;
  endfunction

endpackage

// File: rtl/rng_word_packer_if.sv
// Bit-in / word-out stream bundle of the RNG word packer.
// master: the packer (consumes bits, produces words); slave: the surrounding logic.
interface rng_word_packer_if #(
  parameter int unsigned WORD_W = 32
) ();

  logic              bit_valid;
  logic              bit_data;
  logic              word_valid;
  logic [WORD_W-1:0] word_data;
  logic              word_ready;

  modport master (
    input  bit_valid,
    input  bit_data,
    input  word_ready,
    output word_valid,
    output word_data
  );

  modport slave (
    output bit_valid,
    output bit_data,
    output word_ready,
    input  word_valid,
    input  word_data
  );

endinterface

// File: rtl/rng_sync_fifo.sv
// Single-clock FIFO with occupancy count; a push into a full FIFO is taken only
// when a pop happens on the same edge.
module rng_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push_c;
  logic             do_pop_c;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head      = mem_q[rd_ptr_q];
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);

  // Storage is cleared on reset so the head word reads as zero when empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= AW'(wr_ptr_q + 1'b1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= AW'(rd_ptr_q + 1'b1);
      end
      case ({do_push_c, do_pop_c})
        2'b10:   count_q <= CNT_W'(count_q + 1'b1);
        2'b01:   count_q <= CNT_W'(count_q - 1'b1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rng_word_packer.sv
// Packs de-biased RNG bits LSB-first into WORD_W-bit words buffered in a FIFO.
// Define RNG_PACK_RCT_EN to add the repetition-count health test and rct_fail output.
module rng_word_packer
  import rng_pkg::*;
#(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          ovf_clr,
  rng_word_packer_if.master             bus,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow
`ifdef RNG_PACK_RCT_EN
  ,
  output logic                          rct_fail
`endif
);

  localparam int unsigned CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

  pack_state_e       state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_c;
  logic              push_c;
  logic              pop_c;
  logic              overflow_d;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef RNG_PACK_RCT_EN
  localparam int unsigned RCT_LIMIT = rct_limit(WORD_W);
  localparam int unsigned RUN_W     = $clog2(RCT_LIMIT + 1);

  logic [RUN_W-1:0] run_q, run_d, run_nxt_c;
  logic             last_q, last_d;
  logic             rct_hit_c;
`endif

  // Incoming bit enters at the MSB so the first bit of a word ends up in bit 0.
  assign word_c = {bus.bit_data, shift_q[WORD_W-1:1]};
  assign pop_c  = bus.word_ready && !fifo_empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      overflow  <= 1'b0;
`ifdef RNG_PACK_RCT_EN
      run_q     <= '0;
      last_q    <= 1'b0;
      rct_fail  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      overflow  <= overflow_d;
`ifdef RNG_PACK_RCT_EN
      run_q     <= run_d;
      last_q    <= last_d;
      rct_fail  <= rct_hit_c;
`endif
    end
  end

  // Collector FSM, bit counter, word completion and overflow tracking.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_c     = 1'b0;
    overflow_d = overflow;
`ifdef RNG_PACK_RCT_EN
    run_d      = run_q;
    last_d     = last_q;
    rct_hit_c  = 1'b0;
    run_nxt_c  = (run_q != '0 && bus.bit_data == last_q) ? RUN_W'(run_q + 1'b1)
                                                         : RUN_W'(1);
`endif

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (!enable) begin
          // Partial word is abandoned; FIFO and output side are untouched.
          state_d   = IDLE;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else if (bus.bit_valid) begin
          shift_d = word_c;
          if (bit_cnt_q == LAST_BIT) begin
            push_c    = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = CNT_W'(bit_cnt_q + 1'b1);
          end
`ifdef RNG_PACK_RCT_EN
          last_d = bus.bit_data;
          run_d  = run_nxt_c;
          if (run_nxt_c == RUN_W'(RCT_LIMIT)) begin
            rct_hit_c = 1'b1;
            run_d     = RUN_W'(1);
            push_c    = 1'b0;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A lost word sets the flag even if a clear arrives on the same edge.
    if (push_c && fifo_full && !pop_c) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  rng_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (word_c),
    .pop       (bus.word_ready),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fill_level),
    .head      (bus.word_data)
  );

  assign bus.word_valid = !fifo_empty;

endmodule

// File: tb/tb_rng_word_packer.sv
// Randomized scoreboard bench for rng_word_packer (WORD_W=8, FIFO_DEPTH=4),
// with directed scenarios for the documented corner cases.
module tb_rng_word_packer;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  enable = 1'b0;
  logic                  ovf_clr = 1'b0;
  logic [$clog2(D):0]    fill_level;
  logic                  overflow;
`ifdef RNG_PACK_RCT_EN
  logic                  rct_fail;
`endif

  rng_word_packer_if #(.WORD_W(W)) bus ();

  rng_word_packer #(
    .WORD_W     (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .ovf_clr    (ovf_clr),
    .bus        (bus),
    .fill_level (fill_level),
    .overflow   (overflow)
`ifdef RNG_PACK_RCT_EN
    ,
    .rct_fail   (rct_fail)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: expected words in order, partial bit list, occupancy.
  logic [W-1:0] exp_q[$];
  bit           part_q[$];
  bit           mdl_collect = 1'b0;
  int           mdl_cnt = 0;
  bit           mdl_ovf = 1'b0;
  int           mdl_run = 0;
  bit           mdl_last = 1'b0;
  bit           mdl_rct = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("word_valid", longint'(bus.word_valid), longint'(mdl_cnt > 0));
    chk("fill_level", longint'(fill_level), longint'(mdl_cnt));
    chk("overflow", longint'(overflow), longint'(mdl_ovf));
`ifdef RNG_PACK_RCT_EN
    chk("rct_fail", longint'(rct_fail), longint'(mdl_rct));
`endif
  endtask

  // Effect of the coming rising edge given the inputs currently driven.
  task automatic model_step();
    bit           pop;
    bit           push;
    bit           taken;
    logic [W-1:0] w;
    pop   = (mdl_cnt > 0) && bus.word_ready;
    push  = 1'b0;
    taken = 1'b0;
    w     = '0;
    mdl_rct = 1'b0;
    if (!mdl_collect) begin
      if (enable) mdl_collect = 1'b1;
    end else if (!enable) begin
      mdl_collect = 1'b0;
      part_q.delete();
    end else if (bus.bit_valid) begin
      part_q.push_back(bus.bit_data);
`ifdef RNG_PACK_RCT_EN
      mdl_run  = (mdl_run > 0 && bus.bit_data == mdl_last) ? mdl_run + 1 : 1;
      mdl_last = bus.bit_data;
      if (mdl_run == int'(W)) begin
        mdl_rct = 1'b1;
        mdl_run = 1;
        part_q.delete();
      end
`endif
      if (part_q.size() == int'(W)) begin
        foreach (part_q[i]) w[i] = part_q[i];
        push = 1'b1;
        part_q.delete();
      end
    end
    if (push) begin
      if (mdl_cnt < int'(D) || pop) begin
        exp_q.push_back(w);
        taken = 1'b1;
      end
    end
    if (push && !taken) mdl_ovf = 1'b1;
    else if (ovf_clr) mdl_ovf = 1'b0;
    mdl_cnt = mdl_cnt + (taken ? 1 : 0) - (pop ? 1 : 0);
  endtask

  task automatic cycle(input logic en, input logic bv, input logic bd, input logic rdy, input logic clr);
    @(posedge clk);
    #1;
    enable        = en;
    bus.bit_valid = bv;
    bus.bit_data  = bd;
    bus.word_ready = rdy;
    ovf_clr       = clr;
    @(negedge clk);
    check_outputs();
    model_step();
  endtask

  task automatic send_bits(input logic [W-1:0] word, input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b1, word[i], rdy, 1'b0);
  endtask

  task automatic idle(input int n, input logic en, input logic rdy);
    for (int i = 0; i < n; i++) cycle(en, 1'b0, 1'b0, rdy, 1'b0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_word_valid", longint'(bus.word_valid), 0);
    chk("rst_word_data", longint'(bus.word_data), 0);
    chk("rst_fill_level", longint'(fill_level), 0);
    chk("rst_overflow", longint'(overflow), 0);
    enable = 1'b0; ovf_clr = 1'b0;
    bus.bit_valid = 1'b0; bus.bit_data = 1'b0; bus.word_ready = 1'b0;
    exp_q.delete();
    part_q.delete();
    mdl_collect = 1'b0; mdl_cnt = 0; mdl_ovf = 1'b0;
    mdl_run = 0; mdl_last = 1'b0; mdl_rct = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Scoreboard monitor: every accepted head word must match the next expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.word_valid === 1'b1 && bus.word_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none at %0t", bus.word_data, $time);
        end else begin
          chk("word_data", longint'(bus.word_data), longint'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] pat;
`ifdef RNG_PACK_RCT_EN
    pat = 8'hA5;
`else
    pat = 8'hFF;
`endif
    bus.bit_valid = 1'b0; bus.bit_data = 1'b0; bus.word_ready = 1'b0;
    do_reset();

    // First word: LSB-first packing and one-cycle latency.
    idle(1, 1'b1, 1'b1);
    send_bits(8'h4D, 8, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("first_word_valid", longint'(bus.word_valid), 1);
    chk("first_word_data", longint'(bus.word_data), 8'h4D);
    idle(2, 1'b1, 1'b1);

    // Fill past capacity with the consumer stalled.
    for (int k = 0; k < 5; k++) send_bits(pat, 8, 1'b0);
    idle(1, 1'b1, 1'b0);
    chk("full_fill_level", longint'(fill_level), 4);
    chk("full_overflow", longint'(overflow), 1);
    chk("full_head", longint'(bus.word_data), longint'(pat));
    idle(5, 1'b1, 1'b1);
    chk("drained_fill_level", longint'(fill_level), 0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1, 1'b0);

    // Push into a full FIFO accepted thanks to a same-edge pop.
    for (int k = 0; k < 4; k++) send_bits(8'h5A, 8, 1'b0);
    send_bits(8'h3C, 7, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b1, 1'b0);
    chk("pushpop_fill_level", longint'(fill_level), 4);
    chk("pushpop_overflow", longint'(overflow), 0);
    idle(6, 1'b1, 1'b1);

    // Enable drop mid-word discards the partial bits.
    send_bits(8'h07, 3, 1'b1);
    idle(1, 1'b0, 1'b1);
    idle(2, 1'b1, 1'b1);
    send_bits(8'hA5, 8, 1'b1);
    idle(3, 1'b1, 1'b1);

    // Reset mid-operation with two queued words and a partial word.
    send_bits(8'h3C, 8, 1'b0);
    send_bits(8'h96, 8, 1'b0);
    send_bits(8'h69, 5, 1'b0);
    idle(1, 1'b1, 1'b0);
    chk("pre_reset_fill", longint'(fill_level), 2);
    do_reset();
    idle(1, 1'b1, 1'b0);
    send_bits(8'hC3, 8, 1'b0);
    idle(1, 1'b1, 1'b0);
    chk("post_reset_fill", longint'(fill_level), 1);
    idle(3, 1'b1, 1'b1);

`ifdef RNG_PACK_RCT_EN
    send_bits(8'hFF, 8, 1'b1);
    idle(1, 1'b1, 1'b1);
    chk("rct_no_word", longint'(fill_level), 0);
`endif

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      cycle(logic'($urandom_range(0, 19) != 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 9) < 6),
            logic'($urandom_range(0, 19) == 0));
    end

    idle(12, 1'b0, 1'b1);
    chk("scoreboard_drained", longint'(exp_q.size()), 0);
    chk("final_fill_level", longint'(fill_level), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rng_word_packer.md
RNG_WORD_PACKER -- requirements
Module: rng_word_packer

Interface
REQ-001 SHALL have parameter WORD_W, default 32: packed output word width; legal range 2..64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4: output FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port enable, input, 1: packing enable, the same signal that enables the upstream de-biaser.
REQ-006 SHALL have port bit_valid, input, 1: de-biased bit strobe (de-biaser valid).
REQ-007 SHALL have port bit_data, input, 1: de-biased bit (de-biaser data).
REQ-008 SHALL have port ovf_clr, input, 1: synchronous clear of the overflow flag.
REQ-009 SHALL have port word_valid, output, 1: FIFO head valid.
REQ-010 SHALL have port word_data, output, WORD_W: FIFO head word.
REQ-011 SHALL have port word_ready, input, 1: consumer accepts the head word.
REQ-012 SHALL have port fill_level, output, $clog2(FIFO_DEPTH)+1: number of FIFO entries occupied.
REQ-013 SHALL have port overflow, output, 1: sticky flag, set when a completed word was lost.

Function
REQ-014 SHALL run an FSM with states IDLE and COLLECT. IDLE->COLLECT when enable=1. COLLECT->IDLE when enable=0.
REQ-015 SHALL accept a bit only in COLLECT with enable=1 and bit_valid=1; bits arriving in IDLE are ignored.
REQ-016 SHALL shift accepted bits in LSB-first: the first accepted bit of a word lands in word_data[0].
REQ-017 SHALL keep bit_cnt (0..WORD_W-1); each accepted bit increments it; the bit that brings it to WORD_W completes the word, and bit_cnt wraps to 0 on that edge.
REQ-018 SHALL push the completed word into the FIFO on the same edge as the completing bit; if the FIFO was empty, word_valid SHALL rise the next cycle (latency 1).
REQ-019 SHALL pop the FIFO on every edge with word_valid=1 and word_ready=1.
REQ-020 SHALL hold word_data stable while word_valid=1 and word_ready=0.
REQ-021 SHALL complete a push into a full FIFO when a pop occurs on the same edge; fill_level is then unchanged.
REQ-022 SHALL drop a word completed while the FIFO is full with no same-edge pop, and set overflow; bit_cnt still wraps.
REQ-023 SHALL give set priority over ovf_clr when both occur on the same edge.
REQ-024 SHALL discard the partial word and clear bit_cnt when enable falls mid-word; FIFO contents and the output handshake SHALL be unaffected.
REQ-025 SHALL keep fill_level exact: +1 on push only, -1 on pop only, unchanged on push+pop or on neither.

Reset
REQ-026 SHALL, on rst=0, immediately set: state=IDLE, bit_cnt=0, shift register=0, FIFO empty, word_valid=0, word_data=0, fill_level=0, overflow=0.
REQ-027 SHALL discard all FIFO contents and any partial word when reset is asserted mid-operation; no word is emitted after release until a full new word is collected.

Configuration
REQ-028 SHALL, with macro RNG_PACK_RCT_EN defined, add a repetition-count health test on accepted bits with localparam RCT_LIMIT=WORD_W (a run of RCT_LIMIT identical accepted bits fails the test).
REQ-029 SHALL, on a health-test failure, discard the partial word, clear bit_cnt, and pulse output rct_fail for one cycle; the run counter SHALL restart at 1 with the current bit.
REQ-030 SHALL, without RNG_PACK_RCT_EN, omit the run counter and the rct_fail port entirely.

Structure
REQ-031 SHALL place the FSM state enum and the RCT_LIMIT derivation in shared package rng_pkg.
REQ-032 SHALL implement the FIFO as a separate sub-module rng_sync_fifo (push/pop/full/empty/count) instantiated once.

Verification
REQ-033 WORD_W=8, enable=1, bits 1,0,1,1,0,0,1,0 with word_ready=1 -> one cycle after the 8th bit, word_valid=1, word_data=8'h4D.
REQ-034 word_ready=0, 5 words of 8'hFF collected -> fill_level=4, overflow=1, then 4 pops return 8'hFF x4, FIFO empty.
REQ-035 FIFO full, 8th bit of a new word accepted on the same edge as word_ready=1 -> fill_level stays 4, overflow=0.
REQ-036 Enable low after 3 bits, then high, then bits 8'hA5 LSB-first -> output 8'hA5 only; the partial word never appears.
REQ-037 rst=0 asserted with fill_level=2 and bit_cnt=5 -> all outputs 0 asynchronously; after release, 8 bits -> exactly one word.
REQ-038 RNG_PACK_RCT_EN, WORD_W=8, 8 consecutive 1s -> rct_fail pulses once, no word is pushed; in the non-RCT build, word_data=8'hFF.
